instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/tinycpu_pkg.sv | 27 ++
 rtl/instr_prog_mem.sv | 24 ++
 rtl/instr_sequencer.sv | 117 +++++++++++
 tb/tb_instr_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/tinycpu_pkg.sv
// rtl/tinycpu_pkg.sv - shared opcodes, program depth and sequencer state type
package tinycpu_pkg;

    localparam int PROG_DEPTH = 16;

    localparam logic [3:0] OP_CLR  = 4'd0;
    localparam logic [3:0] OP_LDA  = 4'd1;
    localparam logic [3:0] OP_LDB0 = 4'd2;
    localparam logic [3:0] OP_LDB1 = 4'd3;
    localparam logic [3:0] OP_ALU0 = 4'd4;
    localparam logic [3:0] OP_ALU1 = 4'd5;
    localparam logic [3:0] OP_ALU2 = 4'd6;
    localparam logic [3:0] OP_ALU3 = 4'd7;
    localparam logic [3:0] OP_ALU4 = 4'd8;
    localparam logic [3:0] OP_ALU5 = 4'd9;
    localparam logic [3:0] OP_ALU6 = 4'd10;
    localparam logic [3:0] OP_ALU7 = 4'd11;
    localparam logic [3:0] OP_END  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/instr_prog_mem.sv
// rtl/instr_prog_mem.sv - 16x4 program store, synchronous write, combinational read
module instr_prog_mem
    import tinycpu_pkg::*;
(
    input  logic       clk,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic [3:0] rd_addr,
    output logic [3:0] rd_data
);

    logic [3:0] mem [PROG_DEPTH];

    // Write port; contents are deliberately not reset, prog_len marks validity
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - program loader and instruction issuer (SEQ_LOOP_EN: wrap instead of DONE)
module instr_sequencer
    import tinycpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_start,
    input  logic       load_valid,
    input  logic [3:0] load_data,
    input  logic       load_last,
    output logic       load_ready,
    input  logic       start,
    input  logic       abort,
    output logic [3:0] instruction,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic       done,
    output logic [4:0] prog_len
);

    localparam logic [4:0] DEPTH = 5'(PROG_DEPTH);

    seq_state_t state, state_n;
    logic [3:0] pc, pc_n;
    logic [4:0] len_n;
    logic [3:0] cur_word;
    logic       wr_en;
    logic       at_end;
    logic       last_word;
    logic       xfer;

    instr_prog_mem u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (prog_len[3:0]),
        .wr_data (load_data),
        .rd_addr (pc),
        .rd_data (cur_word)
    );

    // Outputs decode straight from state so reset clears them immediately
    assign load_ready  = (state == ST_LOAD) && (prog_len < DEPTH);
    assign wr_en       = load_valid && load_ready;
    assign at_end      = (cur_word == OP_END);
    assign last_word   = (({1'b0, pc} + 5'd1) == prog_len);
    assign instr_valid = (state == ST_RUN) && !at_end;
    assign instruction = instr_valid ? cur_word : 4'h0;
    assign xfer        = instr_valid && instr_ready;
    assign done        = (state == ST_DONE);

    // State, program counter and program length registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pc       <= 4'd0;
            prog_len <= 5'd0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            prog_len <= len_n;
        end
    end

    // Next-state logic: abort dominates, load_start beats start in IDLE/DONE
    always_comb begin
        state_n = state;
        pc_n    = pc;
        len_n   = prog_len;
        if (wr_en) begin
            len_n = prog_len + 5'd1;
        end
        if (abort) begin
            state_n = ST_IDLE;
            if (xfer) begin
                pc_n = pc + 4'd1;
            end
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (load_start) begin
                        state_n = ST_LOAD;
                        len_n   = 5'd0;
                    end else if (start) begin
                        pc_n    = 4'd0;
                        state_n = (prog_len == 5'd0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_LOAD: begin
                    if (wr_en && (load_last || (prog_len == DEPTH - 5'd1))) begin
                        state_n = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (at_end) begin
`ifdef SEQ_LOOP_EN
                        pc_n = 4'd0;
`else
                        state_n = ST_DONE;
`endif
                    end else if (xfer) begin
                        if (last_word) begin
`ifdef SEQ_LOOP_EN
                            pc_n = 4'd0;
`else
                            state_n = ST_DONE;
`endif
                        end else begin
                            pc_n = pc + 4'd1;
                        end
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - scoreboard bench for instr_sequencer
module tb_instr_sequencer;
    import tinycpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_start, load_valid, load_last, load_ready;
    logic [3:0] load_data;
    logic       start, abort;
    logic [3:0] instruction;
    logic       instr_valid, instr_ready;
    logic       done;
    logic [4:0] prog_len;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] sb [$];
    logic [3:0] prog [$];

    instr_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .start       (start),
        .abort       (abort),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .done        (done),
        .prog_len    (prog_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_prog(input bit use_last);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < prog.size(); i++) begin
            load_valid = 1'b1;
            load_data  = prog[i];
            load_last  = use_last && (i == prog.size() - 1);
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_data  = 4'h0;
    endtask

    task automatic kick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 60) begin
            tick();
            n++;
        end
        check("done_reached", done, 1);
        check("sb_drained", sb.size(), 0);
    endtask

    // Scoreboard: every handshake pops one expected opcode
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_issue", {28'd0, instruction}, 32'hdead);
            end else begin
                check("issue", {28'd0, instruction}, {28'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        rst_n = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
        load_data = 4'h0; start = 1'b0; abort = 1'b0; instr_ready = 1'b1;
        #1;
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instruction, 0);
        check("rst_done", done, 0);
        check("rst_ready", load_ready, 0);
        check("rst_len", prog_len, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // basic program, back-to-back issue
        prog = '{4'h1, 4'h2, 4'h4};
        load_prog(1'b1);
        check("len3", prog_len, 3);
        check("idle_after_last", 32'(dut.state), 32'(ST_IDLE));
        sb.push_back(4'h1); sb.push_back(4'h2); sb.push_back(4'h4);
        kick();
        check("lat_valid", instr_valid, 1);
        check("lat_instr", instruction, 4'h1);
        tick(); tick(); tick();
        check("done_after_3", done, 1);
        check("sb_after_3", sb.size(), 0);

        // stall holds instruction
        prog = '{4'h1, 4'h3};
        load_prog(1'b1);
        check("len2", prog_len, 2);
        instr_ready = 1'b0;
        sb.push_back(4'h1); sb.push_back(4'h3);
        kick();
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", instr_valid, 1);
            check("stall_instr", instruction, 4'h1);
            tick();
        end
        instr_ready = 1'b1;
        wait_done();

        // load_start wins over start in DONE; no-op opcodes pass through
        start = 1'b1; load_start = 1'b1;
        tick();
        start = 1'b0; load_start = 1'b0;
        check("ls_wins_state", 32'(dut.state), 32'(ST_LOAD));
        check("ls_wins_ready", load_ready, 1);
        check("ls_wins_len", prog_len, 0);
        prog = '{4'hC, 4'hD, 4'hE};
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1; load_data = prog[i]; load_last = (i == 2);
            tick();
        end
        load_valid = 1'b0; load_last = 1'b0;
        sb.push_back(4'hC); sb.push_back(4'hD); sb.push_back(4'hE);
        kick();
        wait_done();

        // OP_END handling
        prog = '{4'h0, 4'h5, 4'hF, 4'h7};
        load_prog(1'b1);
        check("len4", prog_len, 4);
`ifdef SEQ_LOOP_EN
        for (int i = 0; i < 3; i++) begin
            sb.push_back(4'h0); sb.push_back(4'h5);
        end
        kick();
        begin
            int n = 0;
            while (sb.size() > 0 && n < 60) begin
                check("loop_not_done", done, 0);
                tick();
                n++;
            end
        end
        instr_ready = 1'b0;
        check("loop_drained", sb.size(), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        instr_ready = 1'b1;
        check("loop_abort_idle", 32'(dut.state), 32'(ST_IDLE));
`else
        sb.push_back(4'h0); sb.push_back(4'h5);
        kick();
        wait_done();
        check("end_no_valid", instr_valid, 0);
`endif

        // abort during a transfer
        prog = '{4'h1, 4'h2, 4'h3};
        load_prog(1'b1);
        sb.push_back(4'h1);
        kick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", instr_valid, 0);
        check("abort_state", 32'(dut.state), 32'(ST_IDLE));
        check("abort_len", prog_len, 3);
        check("abort_counted", sb.size(), 0);

        // 17 beats, no load_last: fills and stops at 16
        prog.delete();
        for (int i = 0; i < 17; i++) prog.push_back(4'(i % 12));
        load_prog(1'b0);
        check("full_len", prog_len, 16);
        check("full_ready", load_ready, 0);
        check("full_state", 32'(dut.state), 32'(ST_IDLE));
        for (int i = 0; i < 16; i++) sb.push_back(4'(i % 12));
        kick();
        wait_done();

        // reset during LOAD
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_valid = 1'b1; load_data = 4'h6;
        tick();
        load_valid = 1'b0;
        check("mid_load_len", prog_len, 1);
        rst_n = 1'b0;
        #1;
        check("async_len", prog_len, 0);
        check("async_ready", load_ready, 0);
        check("async_state", 32'(dut.state), 32'(ST_IDLE));
        tick();
        rst_n = 1'b1;
        tick();
        kick();
        check("empty_done", done, 1);
        check("empty_valid", instr_valid, 0);
        tick();
        check("empty_sb", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
